// File: rtl/cell_status_scheduler.sv
// Prefetches one row of cell statuses per cell band into a shadow buffer and swaps it
// into the displayed buffer. Game-logic RAM accesses are granted whenever no fetch is running.
module cell_status_scheduler #(
    parameter int COLS     = 8,
    parameter int ROWS     = 8,
    parameter int STATUS_W = 3,
    parameter int CELL_H   = 60
) (
    input  logic                clk_in,
    input  logic                rst,
    input  logic                frame_start,
    input  logic                line_end,
    input  logic                enable,
    input  logic [3:0]          cell_x,
    output logic [STATUS_W-1:0] cell_status,
    output logic [5:0]          ram_addr,
    output logic                ram_we,
    output logic [STATUS_W-1:0] ram_wdata,
    input  logic [STATUS_W-1:0] ram_rdata,
    input  logic                gl_req,
    input  logic                gl_we,
    input  logic [5:0]          gl_addr,
    input  logic [STATUS_W-1:0] gl_wdata,
    output logic                gl_gnt,
    output logic                gl_rvalid,
    output logic [STATUS_W-1:0] gl_rdata,
    output logic                fetch_late
);

    localparam int COL_W  = $clog2(COLS);
    localparam int ROW_W  = $clog2(ROWS);
    localparam int LINE_W = $clog2(CELL_H);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_DRAIN
    } state_e;

    state_e              state_q, state_d;
    logic [COL_W-1:0]    col_q, col_d;
    logic [ROW_W-1:0]    row_q, row_d;
    logic [ROW_W-1:0]    band_q, band_d;
    logic [LINE_W-1:0]   lineInCell_q, lineInCell_d;
    logic                armed_q, armed_d;
    logic                late_q, late_d;
    logic                rdPend_q, rdPend_d;
    logic                rvalid_q, rvalid_d;
    logic [STATUS_W-1:0] rdata_q, rdata_d;
    logic [STATUS_W-1:0] cell_q, cell_d;
    logic [STATUS_W-1:0] active_q [COLS];
    logic [STATUS_W-1:0] active_d [COLS];
    logic [STATUS_W-1:0] shadow_q [COLS];
    logic [STATUS_W-1:0] shadow_d [COLS];

    logic lineEndOnly;
    logic fetchTrig;
    logic swapTrig;
    logic busy;

    // frame_start takes priority over a coincident line_end
    always_comb begin
        lineEndOnly  = line_end & ~frame_start;
        busy         = (state_q != S_IDLE);
        fetchTrig    = frame_start
                     | (lineEndOnly && lineInCell_q == '0 && band_q < ROW_W'(ROWS - 1));
        swapTrig     = lineEndOnly && lineInCell_q == LINE_W'(CELL_H - 1);
        lineInCell_d = lineInCell_q;
        band_d       = band_q;
        if (frame_start) begin
            lineInCell_d = '0;
            band_d       = '0;
        end else if (line_end) begin
            if (lineInCell_q == LINE_W'(CELL_H - 1)) begin
                lineInCell_d = '0;
                if (band_q != ROW_W'(ROWS - 1)) begin
                    band_d = band_q + 1'b1;
                end
            end else begin
                lineInCell_d = lineInCell_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        row_d     = row_q;
        armed_d   = armed_q;
        shadow_d  = shadow_q;
        ram_addr  = '0;
        ram_we    = 1'b0;
        ram_wdata = '0;
        gl_gnt    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (fetchTrig) begin
                    state_d = S_FETCH;
                    col_d   = '0;
                    row_d   = frame_start ? '0 : band_q + 1'b1;
                    armed_d = frame_start;
                end else if (gl_req) begin
                    ram_addr  = gl_addr;
                    ram_we    = gl_we;
                    ram_wdata = gl_wdata;
                    gl_gnt    = 1'b1;
                end
            end
            S_FETCH: begin
                ram_addr = {row_q, col_q};
                // RAM answers one cycle late, so each cycle lands the previous column
                if (col_q != '0) begin
                    shadow_d[col_q - 1'b1] = ram_rdata;
                end
                if (col_q == COL_W'(COLS - 1)) begin
                    state_d = S_DRAIN;
                end else begin
                    col_d = col_q + 1'b1;
                end
            end
            S_DRAIN: begin
                shadow_d[COLS-1] = ram_rdata;
                armed_d          = 1'b0;
                state_d          = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (rst) begin
            ram_addr  = '0;
            ram_we    = 1'b0;
            ram_wdata = '0;
            gl_gnt    = 1'b0;
        end
    end

    // A swap while a fetch is still running displays the partially filled shadow
    always_comb begin
        active_d = active_q;
        late_d   = late_q;
        if (state_q == S_DRAIN && armed_q) begin
            active_d = shadow_d;
        end else if (swapTrig) begin
            active_d = shadow_q;
        end
        if (busy && (fetchTrig || swapTrig)) begin
            late_d = 1'b1;
        end
        cell_d   = '0;
        if (enable && cell_x < 4'(COLS)) begin
            cell_d = active_q[cell_x[COL_W-1:0]];
        end
        rdPend_d = gl_gnt & ~gl_we;
        rvalid_d = rdPend_q;
        rdata_d  = rdPend_q ? ram_rdata : rdata_q;
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q      <= S_IDLE;
            col_q        <= '0;
            row_q        <= '0;
            band_q       <= '0;
            lineInCell_q <= '0;
            armed_q      <= 1'b0;
            late_q       <= 1'b0;
            rdPend_q     <= 1'b0;
            rvalid_q     <= 1'b0;
            rdata_q      <= '0;
            cell_q       <= '0;
            active_q     <= '{default: '0};
            shadow_q     <= '{default: '0};
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            band_q       <= band_d;
            lineInCell_q <= lineInCell_d;
            armed_q      <= armed_d;
            late_q       <= late_d;
            rdPend_q     <= rdPend_d;
            rvalid_q     <= rvalid_d;
            rdata_q      <= rdata_d;
            cell_q       <= cell_d;
            active_q     <= active_d;
            shadow_q     <= shadow_d;
        end
    end

    assign cell_status = cell_q;
    assign gl_rvalid   = rvalid_q;
    assign gl_rdata    = rdata_q;
    assign fetch_late  = late_q;

endmodule

// File: doc/cell_status_scheduler.md
# cell_status_scheduler

Sequences the single-port 8x8 cell-status RAM for the VGA pixel path and shares it with game logic. It prefetches one cell row (8 statuses) per 60-line cell band into a double buffer, so the VGA driver gets `cell_status` every pixel without touching RAM. Game-logic reads and writes are granted only when no display fetch is running.

## Interface
- `COLS`, 8: cells per row; also the number of reads per fetch.
- `ROWS`, 8: cell rows per frame.
- `STATUS_W`, 3: cell-status width.
- `CELL_H`, 60: scanlines per cell row.

Ports:
- `clk_in`  in  1  pixel clock; the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `frame_start`  in  1  one-cycle pulse in vertical blanking, before line 0.
- `line_end`  in  1  one-cycle pulse at the end of each active line.
- `enable`  in  1  high while in the active video region.
- `cell_x`  in  4  current cell column.
- `cell_status`  out  STATUS_W  status of (current band, `cell_x`), registered.
- `ram_addr`  out  6  RAM address {row[2:0], col[2:0]}.
- `ram_we`  out  1  RAM write enable.
- `ram_wdata`  out  STATUS_W  RAM write data.
- `ram_rdata`  in  STATUS_W  RAM read data; 1-cycle read latency.
- `gl_req`  in  1  game-logic access request; held until granted.
- `gl_we`  in  1  1 = write, 0 = read.
- `gl_addr`  in  6  game-logic cell address.
- `gl_wdata`  in  STATUS_W  game-logic write data.
- `gl_gnt`  out  1  one-cycle pulse; the access is issued to RAM in this cycle.
- `gl_rvalid`  out  1  one-cycle pulse the cycle after a read grant.
- `gl_rdata`  out  STATUS_W  read data, valid with `gl_rvalid`.
- `fetch_late`  out  1  sticky error flag; cleared only by `rst`.

## Operation
- **Counters**
  - `line_in_cell` counts 0..CELL_H-1 and `band` counts 0..ROWS-1.
  - `frame_start` clears both.
  - `line_end` increments `line_in_cell`. On wrap from 59 to 0, `band` increments and saturates at 7.
  - If `frame_start` and `line_end` arrive together, `frame_start` wins.
- **Buffers**
  - `active_buf[0..7]` is displayed; `shadow_buf[0..7]` is the fetch target.
  - A swap copies `shadow_buf` into `active_buf`.
- **Fetch triggers**
  - `frame_start`: fetch row 0, with swap-on-completion armed.
  - `line_end` with `line_in_cell == 0` and `band < 7`: fetch row `band + 1` (band value before the increment).
  - `line_end` with `line_in_cell == 59`: swap. If the fetch has not completed, set `fetch_late` and swap anyway.
  - A trigger that arrives while a fetch is in progress is dropped and sets `fetch_late`.
- **FSM**
  - IDLE: on a trigger, go to FETCH with col = 0. Otherwise, if `gl_req` is high, drive `ram_addr = gl_addr`, `ram_we = gl_we`, `ram_wdata = gl_wdata` and pulse `gl_gnt`.
  - FETCH: drive `ram_addr = {row, col}` with `ram_we = 0`, col = 0..7 over 8 cycles, then go to DRAIN.
  - Read data for col c is written to `shadow_buf[c]` one cycle after its address.
  - DRAIN: capture col 7, perform the swap if armed, go to IDLE.
  - A trigger in the same cycle as `gl_req` wins; the game request waits.
- **Pixel output**
  - `cell_status <= (enable && cell_x < 8) ? active_buf[cell_x] : 0`.
- **Game reads**
  - `gl_rdata <= ram_rdata` and `gl_rvalid <= 1` in the cycle after a read grant.
  - Write grants produce no `gl_rvalid`.

## Timing
- Reset values:
  - State IDLE; counters 0; both buffers all 0.
  - `cell_status`, `ram_addr`, `ram_we`, `ram_wdata` all 0.
  - `gl_gnt`, `gl_rvalid`, `gl_rdata`, `fetch_late` all 0.
- Reset mid-fetch aborts the fetch: no swap, no partial flag; an in-flight `gl_rvalid` is suppressed.
- Fetch: the trigger is seen at edge T. Addresses are driven at T+1..T+8, the last capture is at T+9, and the shadow is complete after T+9. For `frame_start`, `active_buf` is updated at T+9.
- Pixel path: `cell_status` follows `cell_x`/`enable` with 1-cycle latency.
- Game access: worst-case wait is 10 cycles from `gl_req` to `gl_gnt`. In IDLE with no trigger, `gl_gnt` comes the same cycle as `gl_req`. Back-to-back grants are allowed every cycle.
- RAM writes occur only in cycles where `gl_gnt = 1`.

## Test plan
- **Reset behaviour:** assert `rst` with `gl_req = 1` → all outputs 0, no `gl_gnt` during reset.
- **Frame-start fetch:** preload RAM row 0 with cols = 0..7; pulse `frame_start` → `ram_addr` 0..7 on T+1..T+8. After T+9, with `enable = 1` and `cell_x = 5`, the next cycle shows `cell_status = 5`.
- **Band advance:** `frame_start`, then 60 `line_end` pulses with row 1 preloaded to value 3 → fetch of addresses 8..15 after the 1st `line_end`; `cell_status = 3` only after the 60th.
- **Contention:** `gl_req` write (addr 9, data 6) in the same cycle as a fetch trigger → `gl_gnt` exactly one cycle after DRAIN, `ram_we = 1`; readback from addr 9 gives `gl_rvalid` with `gl_rdata = 6`.
- **Late fetch:** pulse a fetch trigger, then a swap `line_end` (`line_in_cell` at 59) 3 cycles later → `fetch_late` = 1 and stays 1 until `rst`.
- **Reset during FETCH:** `rst` at T+4 → IDLE, `active_buf` unchanged (zeros), `ram_addr = 0`, next `gl_req` granted immediately.
